// File: rtl/seg7_scan_ctrl_if.sv
// Bus bundle between a host and the 7-segment scan controller.
// The host drives data/strobes; the controller drives anodes, segments and status.
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      ENABLE;
    logic                      LOAD;
    logic [4*NUM_DIGITS-1:0]   DATA_IN;
    logic [NUM_DIGITS-1:0]     DP_IN;
    logic [NUM_DIGITS-1:0]     AN;
    logic [7:0]                SEG;
    logic                      FRAME_DONE;
    logic                      PENDING;

    modport master (
        output ENABLE, LOAD, DATA_IN, DP_IN,
        input  AN, SEG, FRAME_DONE, PENDING
    );

    modport slave (
        input  ENABLE, LOAD, DATA_IN, DP_IN,
        output AN, SEG, FRAME_DONE, PENDING
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display with
// built-in prescaler, inter-digit blanking and frame-synchronous double buffering.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV          = 20000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic             CLK,
    input  logic             RST,
    seg7_scan_ctrl_if.slave  bus
);

    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int CNT_W  = $clog2(DIV);
    localparam int BCNT_W = $clog2(BLANK_CYCLES + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [BCNT_W-1:0]        bcnt_q, bcnt_d;

    logic [4*NUM_DIGITS-1:0]  active_data_q, active_data_d;
    logic [NUM_DIGITS-1:0]    active_dp_q, active_dp_d;
    logic [4*NUM_DIGITS-1:0]  shadow_data_q, shadow_data_d;
    logic [NUM_DIGITS-1:0]    shadow_dp_q, shadow_dp_d;
    logic                     pending_q, pending_d;

    logic [NUM_DIGITS-1:0]    an_q, an_d;
    logic [7:0]               seg_q, seg_d;
    logic                     frame_done_q, frame_done_d;
    logic                     commit;

    // Active-low segment pattern (g..a) for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= OFF;
            idx_q         <= '0;
            cnt_q         <= '0;
            bcnt_q        <= '0;
            active_data_q <= '0;
            active_dp_q   <= '0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            pending_q     <= 1'b0;
            an_q          <= '1;
            seg_q         <= 8'hFF;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            bcnt_q        <= bcnt_d;
            active_data_q <= active_data_d;
            active_dp_q   <= active_dp_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            pending_q     <= pending_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_done_q  <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        bcnt_d       = bcnt_q;
        frame_done_d = 1'b0;
        commit       = 1'b0;

        case (state_q)
            OFF: begin
                idx_d  = '0;
                cnt_d  = '0;
                bcnt_d = '0;
                commit = pending_q;
                if (bus.ENABLE) begin
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (!bus.ENABLE) begin
                    state_d = OFF;
                    idx_d   = '0;
                    cnt_d   = '0;
                    bcnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = BLANK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BLANK: begin
                // Dropping ENABLE here aborts the frame without a commit or FRAME_DONE.
                if (!bus.ENABLE) begin
                    state_d = OFF;
                    idx_d   = '0;
                    cnt_d   = '0;
                    bcnt_d  = '0;
                end else if (bcnt_q == BCNT_LAST) begin
                    bcnt_d  = '0;
                    state_d = SHOW;
                    if (idx_q == IDX_LAST) begin
                        idx_d        = '0;
                        frame_done_d = 1'b1;
                        commit       = pending_q;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = OFF;
                idx_d   = '0;
                cnt_d   = '0;
                bcnt_d  = '0;
            end
        endcase

        // Commit reads the old shadow, so a LOAD on the same edge stays pending.
        active_data_d = commit ? shadow_data_q : active_data_q;
        active_dp_d   = commit ? shadow_dp_q   : active_dp_q;
        shadow_data_d = bus.LOAD ? bus.DATA_IN : shadow_data_q;
        shadow_dp_d   = bus.LOAD ? bus.DP_IN   : shadow_dp_q;
        pending_d     = bus.LOAD | (pending_q & ~commit);

        an_d  = '1;
        seg_d = 8'hFF;
        if (state_d == SHOW) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_d[i] = (idx_d != IDX_W'(i));
            end
            seg_d = {~active_dp_d[idx_d],
                     hex_to_seg(active_data_d[{idx_d, 2'b00} +: 4])};
        end
    end

    assign bus.AN         = an_q;
    assign bus.SEG        = seg_q;
    assign bus.FRAME_DONE = frame_done_q;
    assign bus.PENDING    = pending_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed scoreboard bench for seg7_scan_ctrl with a 6-clock slot / 24-clock frame.
module tb_seg7_scan_ctrl;

    localparam int NUM_DIGITS   = 4;
    localparam int DIV          = 4;
    localparam int BLANK_CYCLES = 2;
    localparam int SLOT         = DIV + BLANK_CYCLES;
    localparam int FRAME        = NUM_DIGITS * SLOT;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg7_scan_ctrl_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

    seg7_scan_ctrl #(
        .NUM_DIGITS   (NUM_DIGITS),
        .DIV          (DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic ld, input logic [15:0] data, input logic [3:0] dp);
        bus.ENABLE  = en;
        bus.LOAD    = ld;
        bus.DATA_IN = data;
        bus.DP_IN   = dp;
    endtask

    // Expected view of a frame, sampled once per clock, starting at the enable/boundary edge.
    task automatic push_frame(input logic [15:0] data, input logic [3:0] dp, input logic fd_first, input int ncycles);
        exp_t e;
        int   d;
        for (int c = 0; c < ncycles; c++) begin
            d = c / SLOT;
            if ((c % SLOT) < DIV) begin
                e.an  = ~(4'b0001 << d);
                e.seg = {~dp[d], seg_tbl[data[d*4 +: 4]][6:0]};
            end else begin
                e.an  = 4'b1111;
                e.seg = 8'hFF;
            end
            e.fd = fd_first && (c == 0);
            sb_q.push_back(e);
        end
    endtask

    task automatic push_dark(input int ncycles);
        for (int c = 0; c < ncycles; c++) begin
            sb_q.push_back('{an: 4'b1111, seg: 8'hFF, fd: 1'b0});
        end
    endtask

    task automatic run_cycles(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            checks++;
            assert (sb_q.size() != 0) else begin
                failures++;
                $error("[TB] FAIL sb_empty observed=0 entries expected=at least 1");
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                checkOutput($sformatf("AN@t%0t", $time), {12'h0, bus.AN}, {12'h0, e.an});
                checkOutput($sformatf("SEG@t%0t", $time), {8'h0, bus.SEG}, {8'h0, e.seg});
                checkOutput($sformatf("FRAME_DONE@t%0t", $time), {15'h0, bus.FRAME_DONE}, {15'h0, e.fd});
            end
        end
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 16'h0000, 4'b0000);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        $display("[TB] idle after reset");
        checkOutput("reset_pending", {15'h0, bus.PENDING}, 16'h0);
        push_dark(8);
        run_cycles(8);
        checkOutput("idle_pending", {15'h0, bus.PENDING}, 16'h0);

        $display("[TB] load 1234 while off, then enable");
        applyStimulus(1'b0, 1'b1, 16'h1234, 4'b0001);
        push_dark(1);
        run_cycles(1);
        applyStimulus(1'b0, 1'b0, 16'h1234, 4'b0001);
        checkOutput("off_load_pending", {15'h0, bus.PENDING}, 16'h1);
        push_dark(1);
        run_cycles(1);
        checkOutput("off_commit_pending", {15'h0, bus.PENDING}, 16'h0);
        applyStimulus(1'b1, 1'b0, 16'h1234, 4'b0001);
        push_frame(16'h1234, 4'b0001, 1'b0, FRAME);
        push_frame(16'h1234, 4'b0001, 1'b1, FRAME);
        run_cycles(2 * FRAME);

        $display("[TB] mid-frame load ABCD");
        push_frame(16'h1234, 4'b0001, 1'b1, FRAME);
        push_frame(16'hABCD, 4'b0000, 1'b1, FRAME);
        run_cycles(8);
        applyStimulus(1'b1, 1'b1, 16'hABCD, 4'b0000);
        run_cycles(1);
        applyStimulus(1'b1, 1'b0, 16'hABCD, 4'b0000);
        checkOutput("midframe_pending", {15'h0, bus.PENDING}, 16'h1);
        run_cycles(FRAME - 9);
        run_cycles(1);
        checkOutput("boundary_commit_pending", {15'h0, bus.PENDING}, 16'h0);
        run_cycles(FRAME - 1);

        $display("[TB] load on the frame boundary edge");
        push_frame(16'hABCD, 4'b0000, 1'b1, FRAME);
        push_frame(16'h0000, 4'b0000, 1'b1, FRAME);
        push_frame(16'hFFFF, 4'b1010, 1'b1, FRAME);
        run_cycles(8);
        applyStimulus(1'b1, 1'b1, 16'h0000, 4'b0000);
        run_cycles(1);
        applyStimulus(1'b1, 1'b0, 16'h0000, 4'b0000);
        run_cycles(FRAME - 9);
        applyStimulus(1'b1, 1'b1, 16'hFFFF, 4'b1010);
        run_cycles(1);
        applyStimulus(1'b1, 1'b0, 16'hFFFF, 4'b1010);
        checkOutput("boundary_load_pending", {15'h0, bus.PENDING}, 16'h1);
        run_cycles(FRAME - 1);
        run_cycles(1);
        checkOutput("second_commit_pending", {15'h0, bus.PENDING}, 16'h0);
        run_cycles(FRAME - 1);

        $display("[TB] disable during digit 2, then re-enable");
        push_frame(16'hFFFF, 4'b1010, 1'b1, 2 * SLOT + 1);
        run_cycles(2 * SLOT + 1);
        applyStimulus(1'b0, 1'b0, 16'hFFFF, 4'b1010);
        push_dark(3);
        run_cycles(3);
        applyStimulus(1'b1, 1'b0, 16'hFFFF, 4'b1010);
        push_frame(16'hFFFF, 4'b1010, 1'b0, FRAME);
        push_frame(16'hFFFF, 4'b1010, 1'b1, FRAME);
        run_cycles(2 * FRAME);

        $display("[TB] asynchronous reset mid-show");
        push_frame(16'hFFFF, 4'b1010, 1'b1, 2);
        applyStimulus(1'b1, 1'b1, 16'h5678, 4'b0000);
        run_cycles(1);
        applyStimulus(1'b1, 1'b0, 16'h5678, 4'b0000);
        checkOutput("pre_reset_pending", {15'h0, bus.PENDING}, 16'h1);
        run_cycles(1);
        #2 RST = 1'b1;
        #1;
        checkOutput("async_rst_an", {12'h0, bus.AN}, 16'h000F);
        checkOutput("async_rst_seg", {8'h0, bus.SEG}, 16'h00FF);
        checkOutput("async_rst_pending", {15'h0, bus.PENDING}, 16'h0);
        checkOutput("async_rst_fd", {15'h0, bus.FRAME_DONE}, 16'h0);
        @(negedge CLK);
        RST = 1'b0;
        push_frame(16'h0000, 4'b0000, 1'b0, FRAME);
        run_cycles(FRAME);
        checkOutput("post_reset_pending", {15'h0, bus.PENDING}, 16'h0);

        checkOutput("sb_drained", 16'(sb_q.size()), 16'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexing scan controller for the board's common-anode 7-segment display. It sequences NUM_DIGITS digits: each digit is shown for DIV clocks, then all digits are blanked for BLANK_CYCLES clocks to stop ghosting. Digit data is double-buffered and only takes effect at frame boundaries, so the display never tears. The prescaler is built in, so the block runs directly on the system clock.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8).
DIV, 20000, clocks each digit is lit per scan slot (>=2).
BLANK_CYCLES, 16, clocks of all-off between digit slots (>=1).

Ports:
CLK  input  1  system clock; all logic on posedge.
RST  input  1  asynchronous, active-high reset.
ENABLE  input  1  1 = scan running; 0 = display dark.
LOAD  input  1  single-cycle strobe; captures DATA_IN/DP_IN into the shadow buffer.
DATA_IN  input  4*NUM_DIGITS  hex nibbles. Digit i uses bits [4i+3:4i]. Digit 0 is the rightmost.
DP_IN  input  NUM_DIGITS  decimal point per digit, 1 = lit.
AN  output  NUM_DIGITS  digit anode enables, active-low, one-hot-low when lit.
SEG  output  8  active-low segments. Bits 0..6 = segments a..g; bit 7 = dp.
FRAME_DONE  output  1  one-clock pulse at each frame boundary.
PENDING  output  1  1 = shadow buffer holds data not yet committed.

Behaviour:
- Reset (asynchronous, RST=1):
  - AN = all 1s, SEG = 8'hFF, FRAME_DONE = 0, PENDING = 0.
  - Active and shadow buffers cleared to 0.
  - State = OFF, digit index = 0, prescaler = 0.
- Registers: all outputs are registered. AN/SEG change on the clock edge where the state/index changes, never combinationally from inputs.
- States:
  - OFF: AN all 1s, SEG 8'hFF, index 0, counter 0. If ENABLE=1 at an edge -> SHOW; AN[0] goes low at that same edge.
  - SHOW: AN[idx]=0, all other AN bits = 1. SEG = decode(active nibble idx), with SEG[7] = ~active DP[idx]. Counter counts 0..DIV-1. At count DIV-1: counter -> 0, state -> BLANK.
  - BLANK: AN all 1s, SEG 8'hFF for BLANK_CYCLES clocks. At the last clock: idx advances (wraps NUM_DIGITS-1 -> 0), state -> SHOW.
- Frame boundary: the edge where BLANK exits with idx = NUM_DIGITS-1.
  - FRAME_DONE = 1 for exactly that one clock.
  - If PENDING = 1, shadow -> active and PENDING -> 0 on that edge. Digit 0 of the new frame shows the new data.
- Scan period: one slot = DIV + BLANK_CYCLES clocks; one frame = NUM_DIGITS * (DIV + BLANK_CYCLES) clocks.
- LOAD=1 at an edge: shadow <= DATA_IN/DP_IN, PENDING <= 1. Several LOADs within one frame: the last one wins.
- LOAD on the frame-boundary edge: the commit uses the old shadow contents; the new data is captured into shadow; PENDING stays 1.
- While OFF: if PENDING = 1, shadow commits to active on the next edge (PENDING -> 0). Enabling therefore always shows the newest data. A LOAD on that same edge captures into shadow and PENDING stays 1.
- ENABLE dropping mid-scan (any state): next edge -> OFF, outputs dark, idx/counter cleared, no FRAME_DONE. A partial frame never commits.
- RST mid-operation: immediate return to the reset values above; loaded data is lost.
- Decode table, nibble -> SEG[6:0] shown as SEG with dp off:
  - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
  - 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E
- Counter width: $clog2(DIV); blank counter width: $clog2(BLANK_CYCLES+1). There is no overflow path; wrap happens only at the terminal counts.

Test Plan:
(All with DIV=4, BLANK_CYCLES=2, NUM_DIGITS=4; slot = 6 clocks, frame = 24 clocks.)
1. Reset, ENABLE=0 -> AN=4'b1111, SEG=8'hFF, PENDING=0, FRAME_DONE=0 held indefinitely.
2. LOAD DATA_IN=16'h1234, DP_IN=4'b0001 while OFF, then ENABLE=1 -> digit sequence and timing:
   - Digit 0: AN=1110, SEG=0x19 (4 with dp lit) for 4 clocks, then 2 clocks AN=1111/SEG=FF.
   - Digit 1: AN=1101, SEG=B0.
   - Digit 2: AN=1011, SEG=A4.
   - Digit 3: AN=0111, SEG=F9.
   - FRAME_DONE pulses once per 24 clocks.
3. Mid-frame LOAD 16'hABCD -> PENDING=1. Remaining digits of the current frame still show 1234. At the boundary PENDING -> 0; the next frame's digit 0 shows SEG=A1 (d).
4. LOAD asserted exactly on the FRAME_DONE edge with 16'hFFFF after an earlier pending 16'h0000 -> the next frame shows 0000, PENDING stays 1, and the following frame shows FFFF.
5. ENABLE=0 during digit 2 -> next clock AN=1111; re-enable -> scan restarts at digit 0 with a full 4-clock slot, and there is no FRAME_DONE for the aborted frame.
6. RST pulsed asynchronously mid-SHOW (between clock edges) -> AN=1111/SEG=FF immediately. After release with ENABLE=1, digit 0 shows SEG=C0 (buffers cleared).
